// File: rtl/sn74_scan_demux.sv
// Scanning demultiplexer for a remote '151-style selector: steps the select bus,
// samples the selector's Y output per channel and presents each finished frame as a held word.
module sn74_scan_demux #(
  parameter int CHANNELS = 8,
  parameter int SEL_W    = 3,
  parameter int SETTLE   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                clr,
  input  logic                din,
  output logic [SEL_W-1:0]    sel,
  output logic                str,
  output logic [CHANNELS-1:0] q,
  output logic                q_valid,
  output logic                busy
);

  // state    | meaning
  // S_IDLE   | strobe high, select parked at 0, waiting for en
  // S_SETTLE | select stable, waiting SETTLE cycles for the remote mux to propagate
  // S_SAMPLE | one cycle; din captured into shadow[sel] on the closing edge
  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE
  } state_t;

  localparam state_t           RUN_STATE = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;
  localparam logic [3:0]       SETTLE_LD = 4'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [SEL_W-1:0] LAST_SEL  = SEL_W'(CHANNELS - 1);

  state_t              state, state_nxt;
  logic [3:0]          cnt, cnt_nxt;
  logic [SEL_W-1:0]    sel_nxt;
  logic [CHANNELS-1:0] shadow, shadow_nxt;
  logic                frame_done;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    sel_nxt    = sel;
    shadow_nxt = shadow;
    frame_done = 1'b0;
    case (state)
      S_IDLE: begin
        if (en) begin
          state_nxt = RUN_STATE;
          cnt_nxt   = SETTLE_LD;
        end
      end
      S_SETTLE: begin
        if (cnt == 4'd0) state_nxt = S_SAMPLE;
        else             cnt_nxt   = cnt - 4'd1;
      end
      S_SAMPLE: begin
        shadow_nxt[sel] = din;
        if (sel == LAST_SEL) begin
          frame_done = 1'b1;
          sel_nxt    = '0;
          state_nxt  = en ? RUN_STATE : S_IDLE;
        end else begin
          sel_nxt   = sel + 1'b1;
          state_nxt = RUN_STATE;
        end
        cnt_nxt = SETTLE_LD;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // clr outranks a coincident frame load, so that frame is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      sel     <= '0;
      shadow  <= '0;
      q       <= '0;
      q_valid <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      sel     <= sel_nxt;
      shadow  <= shadow_nxt;
      q_valid <= 1'b0;
      if (clr) begin
        q <= '0;
      end else if (frame_done) begin
        q       <= shadow_nxt;
        q_valid <= 1'b1;
      end
    end
  end

  assign str  = (state == S_IDLE);
  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_sn74_scan_demux.sv
// Bench for sn74_scan_demux: behavioural '151 on the far side, expected frames derived
// from channel sample times (channel k of frame f sampled at edge f*F + (k+1)*(SETTLE+1)).
module tb_sn74_scan_demux;
  localparam int S  = 1;
  localparam int F  = 8 * (S + 1);

  logic       clk = 1'b0;
  logic       rst, en, clr;
  logic [7:0] sw;
  logic       din;
  logic [2:0] sel;
  logic       str;
  logic [7:0] q;
  logic       q_valid, busy;

  logic       en4;
  logic [3:0] sw4;
  logic       din4;
  logic [1:0] sel4;
  logic       str4;
  logic [3:0] q4;
  logic       q_valid4, busy4;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q;

  always #5 clk = ~clk;

  // remote selector: Y follows the selected input, forced low while strobed off
  assign din  = str  ? 1'b0 : sw[sel];
  assign din4 = str4 ? 1'b0 : sw4[sel4];

  sn74_scan_demux #(.CHANNELS(8), .SEL_W(3), .SETTLE(S)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .din(din),
    .sel(sel), .str(str), .q(q), .q_valid(q_valid), .busy(busy)
  );

  sn74_scan_demux #(.CHANNELS(4), .SEL_W(2), .SETTLE(0)) dut4 (
    .clk(clk), .rst(rst), .en(en4), .clr(clr), .din(din4),
    .sel(sel4), .str(str4), .q(q4), .q_valid(q_valid4), .busy(busy4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs `frames` frames from IDLE; inputs switch d0->d1 after edge chg, en drops after
  // edge drop, clr is high for the edge clr_edge (edges counted from edge 0).
  task automatic scan(input int frames, input logic [7:0] d0, input logic [7:0] d1,
                      input int chg, input int drop, input int clr_edge);
    int         last;
    int         f;
    int         e;
    bit         eof;
    bit         qv_exp;
    logic [7:0] word;
    last = frames * F;
    sw   = d0;
    clr  = 1'b0;
    en   = 1'b1;
    tick();
    for (int t = 0; t <= last; t++) begin
      eof    = (t > 0) && (t % F == 0);
      qv_exp = 1'b0;
      if (t == clr_edge) begin
        exp_q = '0;
      end else if (eof) begin
        f = t / F - 1;
        for (int k = 0; k < 8; k++) begin
          e       = f * F + (k + 1) * (S + 1);
          word[k] = (e > chg) ? d1[k] : d0[k];
        end
        exp_q  = word;
        qv_exp = 1'b1;
      end
      if (t < last) begin
        chk("sel", 32'(sel), 32'((t % F) / (S + 1)));
        chk("busy", 32'(busy), 32'd1);
        chk("str", 32'(str), 32'd0);
      end else begin
        chk("sel_idle", 32'(sel), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("str_idle", 32'(str), 32'd1);
      end
      chk("q", 32'(q), 32'(exp_q));
      chk("q_valid", 32'(q_valid), 32'(qv_exp));
      if (t == chg)  sw  = d1;
      if (t == drop) en  = 1'b0;
      clr = (t + 1 == clr_edge);
      if (t < last) tick();
    end
    clr = 1'b0;
    tick();
    chk("q_valid_pulse", 32'(q_valid), 32'd0);
    chk("q_hold", 32'(q), 32'(exp_q));
    chk("busy_stay", 32'(busy), 32'd0);
  endtask

  task automatic scan4(input logic [3:0] d);
    sw4 = d;
    en4 = 1'b1;
    tick();
    en4 = 1'b0;
    for (int t = 0; t < 4; t++) begin
      chk("sel4", 32'(sel4), 32'(t));
      chk("busy4", 32'(busy4), 32'd1);
      chk("q_valid4_mid", 32'(q_valid4), 32'd0);
      tick();
    end
    chk("q4", 32'(q4), 32'(d));
    chk("q_valid4", 32'(q_valid4), 32'd1);
    chk("str4_idle", 32'(str4), 32'd1);
    tick();
    chk("q_valid4_pulse", 32'(q_valid4), 32'd0);
  endtask

  initial begin
    int frames, last, chg, drop, ce;
    rst = 1'b1; en = 1'b0; clr = 1'b0; en4 = 1'b0;
    sw = '0; sw4 = '0; exp_q = '0;
    repeat (2) tick();
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_str", 32'(str), 32'd1);
    chk("rst_q", 32'(q), 32'd0);
    chk("rst_q_valid", 32'(q_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();

    scan(1, 8'hA5, 8'hA5, 1000, 0, -1);
    scan(2, 8'hA5, 8'h3C, 20, 20, -1);
    scan(2, 8'hFF, 8'hFF, 1000, 20, F);
    scan(1, 8'($urandom), 8'($urandom), int'($urandom_range(0, F - 1)), 5, -1);

    for (int i = 0; i < 4; i++) begin
      frames = int'($urandom_range(1, 3));
      last   = frames * F;
      chg    = int'($urandom_range(0, last));
      drop   = int'($urandom_range((frames - 1) * F, last - 1));
      ce     = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, last)) : -1;
      scan(frames, 8'($urandom), 8'($urandom), chg, drop, ce);
    end

    scan(1, 8'h5A, 8'h5A, 1000, 0, -1);
    en = 1'b1;
    tick();
    en = 1'b0;
    repeat (8) tick();
    rst = 1'b1;
    tick();
    exp_q = '0;
    chk("mid_rst_sel", 32'(sel), 32'd0);
    chk("mid_rst_str", 32'(str), 32'd1);
    chk("mid_rst_q", 32'(q), 32'd0);
    chk("mid_rst_q_valid", 32'(q_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();
    scan(1, 8'($urandom), 8'($urandom), int'($urandom_range(0, F)), 0, -1);

    scan4(4'b1001);
    scan4(4'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
